game_screen_ctrl: RTL
=====================

Name: game_screen_ctrl

Overview:
- Frame-synchronous sequencer for the screen-overlay draw stage. Selects START, PLAY or FINISH overlay, gates player/game logic, and issues a one-cycle player reset when a new game begins.
- Inputs are player coordinates, current level, vblnk from the VGA timing chain, and two pre-synchronised buttons.
- All screen changes are applied only at frame boundaries, so an overlay never switches mid-frame.

Parameters:
- FINISH_X_LEFT, 500, finish-zone left bound (exclusive)
- FINISH_X_RIGHT, 700, finish-zone right bound (exclusive)
- FINISH_Y_UP, 100, finish-zone top bound (exclusive)
- FINISH_Y_DOWN, 112, finish-zone bottom bound (exclusive)
- FINISH_LEVEL, 2'b11, level on which the finish zone is active
- FINISH_FRAMES, 300, frames FINISH is shown before auto-return (used only with the optional feature)

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- vblnk  in  1  vertical blank from the VGA timing chain
- level  in  2  current level index
- x_value  in  12  player x position
- y_value  in  12  player y position
- start_btn  in  1  start button, already synchronised, level-sensitive
- restart_btn  in  1  restart button, already synchronised, level-sensitive
- screen_sel  out  2  overlay select: 2'b00 = game, 2'b01 = start, 2'b10 = finish; 2'b11 is never driven
- game_en  out  1  high only while in PLAY
- player_rst  out  1  one-cycle pulse when a new game begins
- frame_cnt  out  9  frames spent in the current state, saturating at 511

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - state = START, screen_sel = 2'b01, game_en = 0, player_rst = 0, frame_cnt = 0.
  - All pending flags and edge registers cleared.
- frame_tick: one-cycle pulse on the cycle after vblnk goes 0 -> 1, from a registered copy of vblnk. vblnk already high when reset releases does NOT produce a tick.
- Button edges: rising edges of start_btn and restart_btn set sticky flags start_pend and restart_pend. A held button produces only one edge.
- Finish detect: fin_hit = (level == FINISH_LEVEL) && FINISH_X_LEFT < x_value < FINISH_X_RIGHT && FINISH_Y_UP < y_value < FINISH_Y_DOWN. All comparisons are unsigned and strict. fin_hit sets sticky fin_pend, but only while in PLAY.
- State transitions are evaluated only on frame_tick:
  - START: if start_pend -> PLAY; clear start_pend; assert player_rst.
  - PLAY:
    - if restart_pend -> START; clear both restart_pend and fin_pend.
    - else if fin_pend -> FINISH; clear fin_pend.
  - FINISH:
    - if restart_pend -> START; clear restart_pend and start_pend.
    - start_pend is ignored in FINISH and cleared on exit.
- Simultaneous events:
  - restart_pend has priority over fin_pend in PLAY.
  - A button edge in the same cycle as frame_tick is latched but consumed on the next tick, giving one frame of latency.
  - start_pend set while in PLAY is cleared on every PLAY tick and never carried over.
- Output timing:
  - screen_sel and game_en are registered and change on the cycle after the transitioning frame_tick.
  - player_rst is high for exactly that same one cycle.
- frame_cnt: cleared to 0 on every state change. Otherwise incremented on each frame_tick, saturating at 511 with no wrap.
- FINISH_FRAMES > 511 is illegal, and elaboration errors via $error.
- Reset asserted mid-operation returns the block to START immediately, independent of clk.

Optional Feature:
- Macro: GAME_SCREEN_FINISH_TIMEOUT_EN.
- Defined: in FINISH, on a frame_tick with frame_cnt == FINISH_FRAMES-1, go to START as if restart_pend were set. restart_pend still wins if both occur on the same tick.
- Undefined: FINISH is held until restart or reset; FINISH_FRAMES is unused.

Test Plan:
- Release reset, no buttons, 3 frames -> screen_sel = 01, game_en = 0, frame_cnt = 3.
- Pulse start_btn mid-frame -> on the next frame_tick+1: screen_sel = 00, game_en = 1, player_rst high for exactly 1 cycle, frame_cnt = 0.
- In PLAY, level = 3, x = 600, y = 105 for 1 cycle, then move away -> on the next tick+1: screen_sel = 10, game_en = 0.
- In PLAY, boundary cases -> no transition for each of: level = 3, x = 500, y = 105; level = 3, x = 600, y = 112; level = 2, x = 600, y = 105.
- In PLAY, fin_hit and restart_btn edge in the same frame -> START (screen_sel = 01), not FINISH; subsequent start_btn -> PLAY with player_rst pulse.
- With GAME_SCREEN_FINISH_TIMEOUT_EN and FINISH_FRAMES = 4, enter FINISH -> back to START exactly 4 ticks later. Without the macro -> still FINISH after 600 ticks. Assert rst_n low mid-frame -> screen_sel = 01 asynchronously.

Source files
------------

// File: rtl/game_screen_ctrl.sv
// game_screen_ctrl: frame-synchronous START/PLAY/FINISH overlay sequencer with player-reset pulse.
// Optional: define GAME_SCREEN_FINISH_TIMEOUT_EN to auto-return from FINISH after FINISH_FRAMES frames.
module game_screen_ctrl #(
  parameter logic [11:0] FINISH_X_LEFT  = 12'd500,
  parameter logic [11:0] FINISH_X_RIGHT = 12'd700,
  parameter logic [11:0] FINISH_Y_UP    = 12'd100,
  parameter logic [11:0] FINISH_Y_DOWN  = 12'd112,
  parameter logic [1:0]  FINISH_LEVEL   = 2'b11,
  parameter int unsigned FINISH_FRAMES  = 300
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vblnk,
  input  logic [1:0]  level,
  input  logic [11:0] x_value,
  input  logic [11:0] y_value,
  input  logic        start_btn,
  input  logic        restart_btn,
  output logic [1:0]  screen_sel,
  output logic        game_en,
  output logic        player_rst,
  output logic [8:0]  frame_cnt
);

  typedef enum logic [1:0] {
    ST_START  = 2'b00,
    ST_PLAY   = 2'b01,
    ST_FINISH = 2'b10
  } state_e;

  generate
    if (FINISH_FRAMES > 511) begin : g_bad_finish_frames
      $error("FINISH_FRAMES must not exceed 511");
    end
  endgenerate

  state_e      state_q, state_d;
  logic        vblnk_q;
  logic        start_btn_q, restart_btn_q;
  logic        start_pend_q, start_pend_d;
  logic        restart_pend_q, restart_pend_d;
  logic        fin_pend_q, fin_pend_d;
  logic [8:0]  frame_cnt_q, frame_cnt_d;
  logic [1:0]  screen_sel_q, screen_sel_d;
  logic        game_en_q, game_en_d;
  logic        player_rst_q, player_rst_d;

  logic        frame_tick;
  logic        start_edge, restart_edge;
  logic        fin_hit;
  logic        fin_timeout;
  logic        start_clr, restart_clr, fin_clr;

  // vblnk_q resets high so a vblnk already asserted at reset release is not seen as an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vblnk_q       <= 1'b1;
      start_btn_q   <= 1'b0;
      restart_btn_q <= 1'b0;
    end else begin
      vblnk_q       <= vblnk;
      start_btn_q   <= start_btn;
      restart_btn_q <= restart_btn;
    end
  end

  assign frame_tick   = vblnk & ~vblnk_q;
  assign start_edge   = start_btn & ~start_btn_q;
  assign restart_edge = restart_btn & ~restart_btn_q;

  assign fin_hit = (level == FINISH_LEVEL) &&
                   (x_value > FINISH_X_LEFT) && (x_value < FINISH_X_RIGHT) &&
                   (y_value > FINISH_Y_UP)   && (y_value < FINISH_Y_DOWN);

`ifdef GAME_SCREEN_FINISH_TIMEOUT_EN
  assign fin_timeout = (frame_cnt_q == 9'(FINISH_FRAMES - 1));
`else
  assign fin_timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_START;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; pending flags are only consumed on a frame tick
  always_comb begin
    state_d     = state_q;
    start_clr   = 1'b0;
    restart_clr = 1'b0;
    fin_clr     = 1'b0;
    if (frame_tick) begin
      unique case (state_q)
        ST_START: begin
          if (start_pend_q) begin
            state_d   = ST_PLAY;
            start_clr = 1'b1;
          end
        end
        ST_PLAY: begin
          start_clr = 1'b1;
          if (restart_pend_q) begin
            state_d     = ST_START;
            restart_clr = 1'b1;
            fin_clr     = 1'b1;
          end else if (fin_pend_q) begin
            state_d = ST_FINISH;
            fin_clr = 1'b1;
          end
        end
        ST_FINISH: begin
          if (restart_pend_q || fin_timeout) begin
            state_d     = ST_START;
            restart_clr = 1'b1;
            start_clr   = 1'b1;
          end
        end
        default: state_d = ST_START;
      endcase
    end
  end

  // Clears use the old flag value, so an edge arriving on the tick cycle survives to the next tick.
  always_comb begin
    start_pend_d   = start_edge | (start_pend_q & ~start_clr);
    restart_pend_d = restart_edge | (restart_pend_q & ~restart_clr);
    fin_pend_d     = (fin_hit && (state_q == ST_PLAY)) | (fin_pend_q & ~fin_clr);
  end

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (state_d != state_q) begin
      frame_cnt_d = '0;
    end else if (frame_tick && (frame_cnt_q != '1)) begin
      frame_cnt_d = frame_cnt_q + 9'd1;
    end
  end

  // Output logic, registered below so outputs move on the cycle after the deciding tick
  always_comb begin
    screen_sel_d = 2'b01;
    game_en_d    = 1'b0;
    player_rst_d = 1'b0;
    unique case (state_d)
      ST_PLAY:   screen_sel_d = 2'b00;
      ST_FINISH: screen_sel_d = 2'b10;
      default:   screen_sel_d = 2'b01;
    endcase
    game_en_d    = (state_d == ST_PLAY);
    player_rst_d = (state_q == ST_START) && (state_d == ST_PLAY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_pend_q   <= 1'b0;
      restart_pend_q <= 1'b0;
      fin_pend_q     <= 1'b0;
      frame_cnt_q    <= '0;
      screen_sel_q   <= 2'b01;
      game_en_q      <= 1'b0;
      player_rst_q   <= 1'b0;
    end else begin
      start_pend_q   <= start_pend_d;
      restart_pend_q <= restart_pend_d;
      fin_pend_q     <= fin_pend_d;
      frame_cnt_q    <= frame_cnt_d;
      screen_sel_q   <= screen_sel_d;
      game_en_q      <= game_en_d;
      player_rst_q   <= player_rst_d;
    end
  end

  assign screen_sel = screen_sel_q;
  assign game_en    = game_en_q;
  assign player_rst = player_rst_q;
  assign frame_cnt  = frame_cnt_q;

endmodule
